lcd_bus_sequencer: RTL and testbench

Controller that owns the 16x2 character LCD bus on the ballot-box board. After reset it waits a power-up delay, issues the HD44780 init sequence and then serves byte writes from two requesters (voter UI and tally display), enforcing enable-pulse and execution-time spacing. Asserting FORCE_RESET at any time restarts the full power-up/init sequence, which re-initialises the display.

---
 rtl/lcd_bus_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: owns the 16x2 HD44780 character LCD bus.
// Waits a power-up delay, sends the four-byte init sequence, then serves
// byte writes from two requesters, enforcing EN width and execution waits.
// Optional feature macro: LCD_ARB_RR_EN (round-robin arbitration; default
// build uses fixed priority with REQ0 ahead of REQ1).
module lcd_bus_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 20'hFFFFF,
  parameter int unsigned EN_CYCLES      = 16,
  parameter int unsigned SETTLE_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000
) (
  input  logic       iCLK,
  input  logic       FORCE_RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       RS0,
  input  logic       RS1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  output logic       ACK0,
  output logic       ACK1,
  output logic       oREADY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic       LCD_RW
);

  localparam logic [19:0] PWRUP_LD  = 20'(POWERUP_CYCLES);
  localparam logic [19:0] EN_LD     = 20'(EN_CYCLES);
  localparam logic [19:0] SETTLE_LD = 20'(SETTLE_CYCLES);
  localparam logic [19:0] CLEAR_LD  = 20'(CLEAR_CYCLES);

  typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, HOLD, IDLE} state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        initDone_q, initDone_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        pick0, pick1;
  logic        cntDone;
  logic        longWait;

  function automatic logic [7:0] initByte(input logic [1:0] idx);
    case (idx)
      2'd0:    initByte = 8'h38;
      2'd1:    initByte = 8'h0C;
      2'd2:    initByte = 8'h01;
      default: initByte = 8'h06;
    endcase
  endfunction

  // A wait of N clocks ends on the clock in which the counter reads 1
  assign cntDone  = (cnt_q <= 20'd1);
  assign longWait = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

`ifdef LCD_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin: on a tie, the port not granted last time wins
  always_comb begin
    pick1 = REQ1 && (!REQ0 || !last_q);
    pick0 = REQ0 && !pick1;
  end

  // Last-grant pointer, starts at 1 so REQ0 wins the first tie
  always_ff @(posedge iCLK or negedge FORCE_RESET) begin
    if (!FORCE_RESET) last_q <= 1'b1;
    else              last_q <= last_d;
  end

  // Pointer follows whichever port is ACKed this clock
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (pick0)      last_d = 1'b0;
      else if (pick1) last_d = 1'b1;
    end
  end
`else
  // Fixed priority: REQ0 always beats REQ1
  always_comb begin
    pick0 = REQ0;
    pick1 = REQ1 && !REQ0;
  end
`endif

  assign ACK0   = (state_q == IDLE) && pick0;
  assign ACK1   = (state_q == IDLE) && pick1;
  assign oREADY = (state_q == IDLE) && initDone_q;

  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

  // State and bus registers; reset drops EN at once and restarts power-up
  always_ff @(posedge iCLK or negedge FORCE_RESET) begin
    if (!FORCE_RESET) begin
      state_q    <= PWRUP;
      cnt_q      <= PWRUP_LD;
      idx_q      <= 2'd0;
      initDone_q <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      initDone_q <= initDone_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
    end
  end

  // Next-state logic: waits, init stepping and request service
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    initDone_d = initDone_q;
    data_d     = data_q;
    rs_d       = rs_q;
    en_d       = en_q;
    case (state_q)
      PWRUP: begin
        if (cntDone) begin
          state_d = SETUP;
          idx_d   = 2'd0;
          data_d  = initByte(2'd0);
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      SETUP: begin
        cnt_d   = EN_LD;
        en_d    = 1'b1;
        state_d = EN_HI;
      end
      EN_HI: begin
        if (cntDone) begin
          en_d    = 1'b0;
          cnt_d   = longWait ? CLEAR_LD : SETTLE_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      HOLD: begin
        if (cntDone) begin
          if (!initDone_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            data_d  = initByte(idx_q + 2'd1);
            rs_d    = 1'b0;
            state_d = SETUP;
          end else begin
            initDone_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      IDLE: begin
        if (pick0) begin
          data_d  = DATA0;
          rs_d    = RS0;
          state_d = SETUP;
        end else if (pick1) begin
          data_d  = DATA1;
          rs_d    = RS1;
          state_d = SETUP;
        end
      end
      default: state_d = PWRUP;
    endcase
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer: init sequence timing, single writes,
// arbitration order, mid-pulse reset and early requests.
module tb_lcd_bus_sequencer;

  logic       iCLK = 1'b0;
  logic       FORCE_RESET;
  logic       REQ0, REQ1, RS0, RS1;
  logic [7:0] DATA0, DATA1;
  logic       ACK0, ACK1, oREADY;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_EN, LCD_RW;

  int cyc        = 0;
  int checkCnt   = 0;
  int passCnt    = 0;
  int ackNoReady = 0;
  int ackBoth    = 0;

  logic [7:0] initBytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         initWaits [4] = '{10, 10, 50, 10};
`ifdef LCD_ARB_RR_EN
  int         expOrder  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
  int         expOrder  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif

  lcd_bus_sequencer #(
    .POWERUP_CYCLES(100),
    .EN_CYCLES(4),
    .SETTLE_CYCLES(10),
    .CLEAR_CYCLES(50)
  ) dut (
    .iCLK(iCLK), .FORCE_RESET(FORCE_RESET),
    .REQ0(REQ0), .REQ1(REQ1), .RS0(RS0), .RS1(RS1),
    .DATA0(DATA0), .DATA1(DATA1),
    .ACK0(ACK0), .ACK1(ACK1), .oREADY(oREADY),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN), .LCD_RW(LCD_RW)
  );

  // 10-unit clock period
  always #5 iCLK = ~iCLK;

  // Edge counter used to timestamp events
  always @(posedge iCLK) cyc <= cyc + 1;

  // Watch for grants outside IDLE and for double grants
  always @(negedge iCLK) begin
    if ((ACK0 || ACK1) && !oREADY) ackNoReady <= ackNoReady + 1;
    if (ACK0 && ACK1) ackBoth <= ackBoth + 1;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, actual, actual, expected, expected);
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic rs,
                               input logic [7:0] data);
    if (port == 0) begin REQ0 = req; RS0 = rs; DATA0 = data; end
    else           begin REQ1 = req; RS1 = rs; DATA1 = data; end
  endtask

  // sel: 0 LCD_EN, 1 oREADY, 2 ACK0, 3 ACK1; returns edge count at match
  task automatic waitFor(input int sel, input logic level, input int bound,
                         input string tag, output int at);
    int   n;
    logic v;
    at = -1;
    n  = 0;
    while (at < 0 && n < bound) begin
      @(negedge iCLK);
      n++;
      case (sel)
        0:       v = LCD_EN;
        1:       v = oREADY;
        2:       v = ACK0;
        default: v = ACK1;
      endcase
      if (v == level) at = cyc;
    end
    if (at < 0) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic checkInit(input int rel);
    int tRise, tFall, tReady;
    tFall = rel;
    for (int k = 0; k < 4; k++) begin
      waitFor(0, 1'b1, 1000, "initEnRise", tRise);
      checkOutput($sformatf("initData%0d", k), int'(LCD_DATA), int'(initBytes[k]));
      checkOutput($sformatf("initRs%0d", k), int'(LCD_RS), 0);
      if (k == 0) checkOutput("powerupDelay", tRise - rel, 101);
      else checkOutput($sformatf("initGap%0d", k), tRise - tFall, initWaits[k-1] + 1);
      waitFor(0, 1'b0, 1000, "initEnFall", tFall);
      checkOutput($sformatf("initEnWidth%0d", k), tFall - tRise, 4);
    end
    waitFor(1, 1'b1, 1000, "initReady", tReady);
    checkOutput("initFinalWait", tReady - tFall, initWaits[3]);
  endtask

  task automatic doWrite(input int port, input logic rs, input logic [7:0] data,
                         input int expWait, input string tag);
    int tReady, tRise, tFall, ackEdge;
    waitFor(1, 1'b1, 2000, {tag, "_ready"}, tReady);
    applyStimulus(port, 1'b1, rs, data);
    #1;
    checkOutput({tag, "_ack0"}, int'(ACK0), (port == 0) ? 1 : 0);
    checkOutput({tag, "_ack1"}, int'(ACK1), (port == 1) ? 1 : 0);
    ackEdge = cyc + 1;
    @(negedge iCLK);
    applyStimulus(port, 1'b0, rs, data);
    checkOutput({tag, "_ackPulse"}, int'(ACK0 || ACK1), 0);
    checkOutput({tag, "_readyDrop"}, int'(oREADY), 0);
    checkOutput({tag, "_data"}, int'(LCD_DATA), int'(data));
    checkOutput({tag, "_rs"}, int'(LCD_RS), int'(rs));
    checkOutput({tag, "_enSetup"}, int'(LCD_EN), 0);
    waitFor(0, 1'b1, 100, {tag, "_enRise"}, tRise);
    checkOutput({tag, "_enDelay"}, tRise - ackEdge, 1);
    waitFor(0, 1'b0, 100, {tag, "_enFall"}, tFall);
    checkOutput({tag, "_enWidth"}, tFall - tRise, 4);
    waitFor(1, 1'b1, 200, {tag, "_idle"}, tReady);
    checkOutput({tag, "_hold"}, tReady - tFall, expWait);
    checkOutput({tag, "_occupancy"}, tReady - ackEdge, 5 + expWait);
  endtask

  initial begin
    int rel, t, n, guard, got0, got1;
    int order [8];

    FORCE_RESET = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge iCLK);

    // Reset values
    checkOutput("rstEn",    int'(LCD_EN),   0);
    checkOutput("rstData",  int'(LCD_DATA), 0);
    checkOutput("rstRs",    int'(LCD_RS),   0);
    checkOutput("rstRw",    int'(LCD_RW),   0);
    checkOutput("rstAck0",  int'(ACK0),     0);
    checkOutput("rstAck1",  int'(ACK1),     0);
    checkOutput("rstReady", int'(oREADY),   0);

    // Power-up and init sequence with no requests
    FORCE_RESET = 1'b1;
    rel = cyc;
    checkInit(rel);

    // Single writes: data byte, then a Clear command with the long wait
    doWrite(0, 1'b1, 8'h41, 10, "wrData");
    doWrite(1, 1'b0, 8'h01, 50, "wrClear");
    checkOutput("rwConst", int'(LCD_RW), 0);

    // Both requesters held, four grants each
    applyStimulus(0, 1'b1, 1'b1, 8'h30);
    applyStimulus(1, 1'b1, 1'b1, 8'h31);
    n = 0; guard = 0; got0 = 0; got1 = 0;
    while (n < 8 && guard < 2000) begin
      @(negedge iCLK);
      guard++;
      if (got0 == 4) REQ0 = 1'b0;
      if (got1 == 4) REQ1 = 1'b0;
      if (ACK0) begin order[n] = 0; n++; got0++; end
      else if (ACK1) begin order[n] = 1; n++; got1++; end
    end
    checkOutput("arbGrantCount", n, 8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("arbOrder%0d", i), (i < n) ? order[i] : -1, expOrder[i]);
    @(negedge iCLK);
    REQ0 = 1'b0;
    REQ1 = 1'b0;

    // Reset in the second clock of an EN pulse with REQ1 pending
    waitFor(1, 1'b1, 2000, "midRstReady", t);
    applyStimulus(0, 1'b1, 1'b1, 8'h55);
    @(negedge iCLK);
    applyStimulus(0, 1'b0, 1'b1, 8'h55);
    waitFor(0, 1'b1, 100, "midRstEn", t);
    @(posedge iCLK);
    #2;
    FORCE_RESET = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 8'h80);
    #1;
    checkOutput("midRstEnDrop", int'(LCD_EN),   0);
    checkOutput("midRstReady0", int'(oREADY),   0);
    checkOutput("midRstData",   int'(LCD_DATA), 0);
    checkOutput("midRstAck1",   int'(ACK1),     0);
    @(negedge iCLK);
    FORCE_RESET = 1'b1;
    rel = cyc;
    waitFor(1, 1'b1, 1000, "reinitReady", t);
    checkOutput("reinitTime", t - rel, 200);
    checkOutput("reinitAck1", int'(ACK1), 1);
    @(negedge iCLK);
    REQ1 = 1'b0;
    waitFor(1, 1'b1, 2000, "postReinit", t);

    // Request raised during init waits for oREADY
    @(negedge iCLK);
    FORCE_RESET = 1'b0;
    repeat (3) @(negedge iCLK);
    FORCE_RESET = 1'b1;
    rel = cyc;
    repeat (10) @(negedge iCLK);
    applyStimulus(0, 1'b1, 1'b1, 8'h42);
    waitFor(2, 1'b1, 1000, "earlyAck", t);
    checkOutput("earlyAckTime",  t - rel, 200);
    checkOutput("earlyAckReady", int'(oREADY), 1);
    @(negedge iCLK);
    REQ0 = 1'b0;
    waitFor(1, 1'b1, 2000, "finalReady", t);

    checkOutput("ackOutsideIdle", ackNoReady, 0);
    checkOutput("ackDouble",      ackBoth,    0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
